// File: rtl/stack_seq.sv
// Multicycle sequencer for PUSH / POP / JAL link / SP adjust.
// Moore outputs decoded from state; tracks push depth and refuses overflow/underflow.
module stack_seq #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned MEM_WAIT    = 1,
  localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    reg_dst_sel,
  output logic          reg_write,
  output logic [1:0]    wb_sel,
  output logic          alu_a_sp,
  output logic [1:0]    alu_b_sel,
  output logic          alu_sub,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] depth
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PUSH_DEC = 4'd1,
    S_PUSH_WR  = 4'd2,
    S_POP_RD   = 4'd3,
    S_POP_WAIT = 4'd4,
    S_POP_WB   = 4'd5,
    S_POP_INC  = 4'd6,
    S_JAL_WB   = 4'd7,
    S_ADJ_WB   = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_JAL   = 2'b10,
    OP_SPADJ = 2'b11
  } op_t;

  localparam logic [2:0]    WAIT_LAST = 3'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic          r_err;
  logic [2:0]    r_wait;
  logic [DW-1:0] r_depth;
  logic          w_full;
  logic          w_empty;
  logic          w_refuse;
  op_t           w_op;

  assign w_op     = op_t'(op);
  assign w_full   = (r_depth == DEPTH_MAX);
  assign w_empty  = (r_depth == '0);
  assign w_refuse = ((w_op == OP_PUSH) && w_full) || ((w_op == OP_POP) && w_empty);
  assign depth    = r_depth;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_wait  <= '0;
      r_depth <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE)
        r_err <= start && w_refuse;
      if (r_state == S_POP_WAIT)
        r_wait <= r_wait + 3'd1;
      else
        r_wait <= '0;
      if (r_state == S_PUSH_WR)
        r_depth <= r_depth + DW'(1);
      else if (r_state == S_POP_INC)
        r_depth <= r_depth - DW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_refuse)
            w_next = S_DONE;
          else begin
            case (w_op)
              OP_PUSH:  w_next = S_PUSH_DEC;
              OP_POP:   w_next = S_POP_RD;
              OP_JAL:   w_next = S_JAL_WB;
              default:  w_next = S_ADJ_WB;
            endcase
          end
        end
      end
      S_PUSH_DEC: w_next = S_PUSH_WR;
      S_PUSH_WR:  w_next = S_DONE;
      S_POP_RD:   w_next = (MEM_WAIT == 0) ? S_POP_WB : S_POP_WAIT;
      S_POP_WAIT: w_next = (r_wait == WAIT_LAST) ? S_POP_WB : S_POP_WAIT;
      S_POP_WB:   w_next = S_POP_INC;
      S_POP_INC:  w_next = S_DONE;
      S_JAL_WB:   w_next = S_DONE;
      S_ADJ_WB:   w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    reg_dst_sel = 3'b000;
    reg_write   = 1'b0;
    wb_sel      = 2'b00;
    alu_a_sp    = 1'b0;
    alu_b_sel   = 2'b00;
    alu_sub     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (r_state)
      S_PUSH_DEC: begin
        busy        = 1'b1;
        reg_write   = 1'b1;
        reg_dst_sel = 3'b011;
        alu_a_sp    = 1'b1;
        alu_b_sel   = 2'b01;
        alu_sub     = 1'b1;
      end
      S_PUSH_WR: begin
        busy      = 1'b1;
        mem_write = 1'b1;
      end
      S_POP_RD, S_POP_WAIT: begin
        busy     = 1'b1;
        mem_read = 1'b1;
      end
      S_POP_WB: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      S_POP_INC: begin
        busy        = 1'b1;
        reg_write   = 1'b1;
        reg_dst_sel = 3'b011;
        alu_a_sp    = 1'b1;
        alu_b_sel   = 2'b01;
      end
      S_JAL_WB: begin
        busy        = 1'b1;
        reg_write   = 1'b1;
        reg_dst_sel = 3'b100;
        wb_sel      = 2'b10;
      end
      S_ADJ_WB: begin
        busy        = 1'b1;
        reg_write   = 1'b1;
        reg_dst_sel = 3'b011;
        alu_a_sp    = 1'b1;
        alu_b_sel   = 2'b10;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        err  = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: two instances (MEM_WAIT=1 depth 16, MEM_WAIT=0 depth 4)
// checked per cycle against an operation-level reference of the output sequence.
module tb_stack_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] op_a = 2'b00, op_b = 2'b00;

  logic       busy_a, done_a, err_a, rw_a, asp_a, sub_a, mr_a, mw_a;
  logic [2:0] dst_a;
  logic [1:0] wb_a, bs_a;
  logic [4:0] depth_a;
  logic       busy_b, done_b, err_b, rw_b, asp_b, sub_b, mr_b, mw_b;
  logic [2:0] dst_b;
  logic [1:0] wb_b, bs_b;
  logic [2:0] depth_b;

  stack_seq #(.STACK_DEPTH(16), .MEM_WAIT(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .op(op_a),
    .busy(busy_a), .done(done_a), .err(err_a), .reg_dst_sel(dst_a),
    .reg_write(rw_a), .wb_sel(wb_a), .alu_a_sp(asp_a), .alu_b_sel(bs_a),
    .alu_sub(sub_a), .mem_read(mr_a), .mem_write(mw_a), .depth(depth_a)
  );

  stack_seq #(.STACK_DEPTH(4), .MEM_WAIT(0)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op_b),
    .busy(busy_b), .done(done_b), .err(err_b), .reg_dst_sel(dst_b),
    .reg_write(rw_b), .wb_sel(wb_b), .alu_a_sp(asp_b), .alu_b_sel(bs_b),
    .alu_sub(sub_b), .mem_read(mr_b), .mem_write(mw_b), .depth(depth_b)
  );

  logic [14:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, err_a, dst_a, rw_a, wb_a, asp_a, bs_a, sub_a, mr_a, mw_a};
  assign obs_b = {busy_b, done_b, err_b, dst_b, rw_b, wb_b, asp_b, bs_b, sub_b, mr_b, mw_b};

  int total = 0;
  int bad   = 0;
  int dep_model [2] = '{0, 0};
  int sdepth    [2] = '{16, 4};
  int memwait   [2] = '{1, 0};
  logic [14:0] exp_q [$];

  // busy, done, err, dst, reg_write, wb, alu_a_sp, alu_b, sub, mem_read, mem_write
  function automatic logic [14:0] mk(input logic dn, input logic er, input logic [2:0] dst,
                                     input logic rw, input logic [1:0] wb, input logic asp,
                                     input logic [1:0] bs, input logic sub, input logic mr,
                                     input logic mwr);
    return {1'b1, dn, er, dst, rw, wb, asp, bs, sub, mr, mwr};
  endfunction

  // Expected per-cycle output sequence of one operation; updates the depth model.
  function automatic void build(input int inst, input int op);
    exp_q.delete();
    case (op)
      0: if (dep_model[inst] == sdepth[inst]) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
         else begin
           exp_q.push_back(mk(0, 0, 3'b011, 1, 0, 1, 2'b01, 1, 0, 0));
           exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
           exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
           dep_model[inst]++;
         end
      1: if (dep_model[inst] == 0) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
         else begin
           for (int k = 0; k <= memwait[inst]; k++)
             exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
           exp_q.push_back(mk(0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 0, 0));
           exp_q.push_back(mk(0, 0, 3'b011, 1, 0, 1, 2'b01, 0, 0, 0));
           exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
           dep_model[inst]--;
         end
      2: begin
           exp_q.push_back(mk(0, 0, 3'b100, 1, 2'b10, 0, 0, 0, 0, 0));
           exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         end
      default: begin
           exp_q.push_back(mk(0, 0, 3'b011, 1, 0, 1, 2'b10, 0, 0, 0));
           exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         end
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int cur_obs(input int inst);
    return inst ? int'(obs_b) : int'(obs_a);
  endfunction

  function automatic int cur_depth(input int inst);
    return inst ? int'(depth_b) : int'(depth_a);
  endfunction

  task automatic set_start(input int inst, input logic s, input logic [1:0] o);
    if (inst == 0) begin start_a = s; op_a = o; end
    else begin start_b = s; op_b = o; end
  endtask

  // poke: raise start again in the first busy cycle; it must be ignored.
  task automatic do_op(input int inst, input int op, input bit poke);
    build(inst, op);
    @(negedge clk);
    chk("idle_before", cur_obs(inst), 0);
    set_start(inst, 1'b1, 2'(op));
    @(posedge clk); #1;
    set_start(inst, 1'b0, 2'(op));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (poke && i == 0) set_start(inst, 1'b1, 2'b00);
      chk($sformatf("op%0d_cyc%0d", op, i + 1), cur_obs(inst), int'(exp_q[i]));
      @(posedge clk); #1;
      set_start(inst, 1'b0, 2'b00);
    end
    chk($sformatf("op%0d_idle_after", op), cur_obs(inst), 0);
    chk($sformatf("op%0d_depth", op), cur_depth(inst), dep_model[inst]);
    @(posedge clk); #1;
    chk("stay_idle", cur_obs(inst), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    chk("reset_outs_a", int'(obs_a), 0);
    chk("reset_depth_a", int'(depth_a), 0);
    chk("reset_outs_b", int'(obs_b), 0);
    @(negedge clk); reset = 1'b1;

    // Basic directed sequences on instance A
    do_op(0, 1, 0);      // POP at depth 0: refused
    do_op(0, 0, 0);      // PUSH at depth 0
    do_op(0, 1, 0);      // POP at depth 1, MEM_WAIT=1
    do_op(0, 2, 1);      // JAL with ignored start during busy

    // Fill to 16, then a refused 17th push
    for (int i = 0; i < 17; i++) do_op(0, 0, 0);
    chk("full_depth", int'(depth_a), 16);

    // SPADJ then MEM_WAIT=0 POP at depth 2 on instance B
    do_op(1, 0, 0);
    do_op(1, 0, 0);
    do_op(1, 3, 0);
    do_op(1, 1, 0);
    chk("b_depth_after_pop", int'(depth_b), 1);

    // Reset mid-POP on instance A
    @(negedge clk);
    start_a = 1'b1; op_a = 2'b01;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("midpop_rd", int'(obs_a), int'(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midpop_rst_outs", int'(obs_a), 0);
    chk("midpop_rst_depth", int'(depth_a), 0);
    chk("midpop_rst_depth_b", int'(depth_b), 0);
    dep_model[0] = 0;
    dep_model[1] = 0;
    @(negedge clk); reset = 1'b1;
    do_op(0, 2, 0);

    // Randomized operations on both instances
    for (int n = 0; n < 200; n++)
      do_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
Multicycle sequencer for stack and link operations in the CPU datapath. On a one-cycle start it drives the 3-bit register-destination mux select, the register-file write, the ALU operand/op selects and the memory strobes, in the order needed for PUSH, POP, JAL link and SP adjust. It keeps a push/pop depth counter and refuses overflow and underflow. It sits beside the main control unit, which hands off these opcodes and waits for done.

Parameters:
STACK_DEPTH, 16, maximum outstanding pushes; depth counter width is clog2(STACK_DEPTH+1)
MEM_WAIT, 1, extra read-wait cycles for POP (0..7)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  2  00 PUSH, 01 POP, 10 JAL, 11 SPADJ; latched with start
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse in DONE
err  out  1  high with done when a request was refused
reg_dst_sel  out  3  000 rt field, 011 const 29 (sp), 100 const 31 (ra)
reg_write  out  1  register-file write enable
wb_sel  out  2  00 ALU, 01 MDR, 10 PC
alu_a_sp  out  1  1 selects sp as ALU A
alu_b_sel  out  2  00 reg B, 01 const 4, 10 imm
alu_sub  out  1  1 = subtract, 0 = add
mem_read  out  1  memory read strobe, address = sp
mem_write  out  1  memory write strobe, address = sp, data = rt
depth  out  clog2(STACK_DEPTH+1)  current push depth

Behaviour:
- Reset (reset low, async): state IDLE; depth 0; every output 0 (reg_dst_sel 000, wb_sel 00, alu_b_sel 00).
- Outputs are Moore, decoded from state. Any field not listed for a state is 0.
- States: IDLE, PUSH_DEC, PUSH_WR, POP_RD, POP_WAIT, POP_WB, POP_INC, JAL_WB, ADJ_WB, DONE.
- IDLE: if start, latch op and move on; otherwise hold. start while busy is ignored and not queued.
- PUSH with depth==STACK_DEPTH: goes IDLE→DONE with err=1; nothing is written and depth is unchanged.
- POP with depth==0: same refusal path, err=1.
- PUSH path:
  - PUSH_DEC: reg_write=1, reg_dst_sel=011, wb_sel=00, alu_a_sp=1, alu_b_sel=01, alu_sub=1.
  - PUSH_WR: mem_write=1; depth increments on exit.
  - Then DONE.
- POP path:
  - POP_RD: mem_read=1.
  - POP_WAIT: mem_read=1 for exactly MEM_WAIT cycles using a wait counter. Skipped when MEM_WAIT=0.
  - POP_WB: reg_write=1, reg_dst_sel=000, wb_sel=01.
  - POP_INC: reg_write=1, reg_dst_sel=011, alu_a_sp=1, alu_b_sel=01, alu_sub=0; depth decrements on exit.
  - Then DONE.
- JAL_WB: reg_write=1, reg_dst_sel=100, wb_sel=10; then DONE.
- ADJ_WB: reg_write=1, reg_dst_sel=011, alu_a_sp=1, alu_b_sel=10, alu_sub=0; then DONE. depth is unaffected.
- DONE: done=1 (err as decided), busy=1; next state is IDLE unconditionally. A new start is accepted one cycle after DONE.
- Latency, with start sampled at edge T:
  - PUSH: done at T+3.
  - POP: done at T+4+MEM_WAIT.
  - JAL: done at T+2.
  - SPADJ: done at T+2.
  - Refused request: done at T+1.
- reg_write is never asserted together with mem_write or mem_read.
- Reset mid-operation aborts immediately: no further strobes, depth cleared. A partially updated sp is the main control's responsibility.
- Illegal or unreachable state encodings return to IDLE with all outputs 0.

Test Plan:
- Reset mid-POP (MEM_WAIT=1, reset low at T+2) -> all outputs 0 asynchronously, depth 0, IDLE after release; the next JAL completes normally.
- PUSH at depth 0 -> T+1 reg_write=1, reg_dst_sel=011, alu_sub=1, alu_b_sel=01; T+2 mem_write=1; T+3 done=1, err=0; then depth=1.
- POP at depth 1 (MEM_WAIT=1) -> mem_read at T+1 and T+2; T+3 reg_write, reg_dst_sel=000, wb_sel=01; T+4 reg_dst_sel=011, alu_sub=0; T+5 done; then depth=0.
- POP at depth 0 -> done=1 and err=1 at T+1; no reg_write or mem strobes. 16 PUSHes then a 17th -> err=1, depth stays 16.
- JAL -> T+1 reg_write=1, reg_dst_sel=100, wb_sel=10; T+2 done. A start pulse at T+1 is ignored, and no second operation occurs.
- SPADJ, then MEM_WAIT=0 POP at depth 2 -> SPADJ shows alu_b_sel=10 and done at T+2 with depth unchanged; the POP shows done at T+4 and depth 1.
